outmem_drain: RTL and testbench



---
 rtl/outmem_pkg.sv | 13 +
 rtl/outmem_drain_fifo.sv | 58 +++++
 rtl/outmem_drain.sv | 129 ++++++++++++
 tb/tb_outmem_drain.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/outmem_pkg.sv
// Shared constants and drain FSM state type for the output-memory drain path.
package outmem_pkg;

  localparam int unsigned OUTMEM_DATA_WIDTH = 64;
  localparam int unsigned OUTMEM_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } drain_state_e;

endpackage

// File: rtl/outmem_drain_fifo.sv
// Two-entry FIFO holding {last, data}; simultaneous push and pop is legal at any occupancy.
module outmem_drain_fifo #(
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] dout_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_pop;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign valid_o = (cnt_q != 2'd0);
  assign dout_o  = mem_q[rd_q];
  assign occ_o   = cnt_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    // When full, the write slot is the head being popped this same cycle.
    if (push_i) begin
      mem_d[wr_q] = din_i;
      wr_d        = ~wr_q;
    end
    if (do_pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/outmem_drain.sv
// Drains a wrapping address range of the output memory (port B) onto a valid/ready stream.
// Define OUTMEM_DRAIN_CLEAR_EN to zero each location as it is read (clear-on-read).
module outmem_drain
  import outmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = OUTMEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = OUTMEM_ADDR_WIDTH
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_START,
  input  logic [ADDR_WIDTH-1:0] i_BASE,
  input  logic [ADDR_WIDTH:0]   i_COUNT,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_MEM_EN,
  output logic                  o_MEM_WE,
  output logic [ADDR_WIDTH-1:0] o_MEM_ADDR,
  output logic [DATA_WIDTH-1:0] o_MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] i_MEM_RDATA,
  output logic                  o_TVALID,
  input  logic                  i_TREADY,
  output logic [DATA_WIDTH-1:0] o_TDATA,
  output logic                  o_TLAST
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned FW = DATA_WIDTH + 1;

  drain_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic                  inflight_q, inflight_d;
  logic                  infl_last_q, infl_last_d;
  logic                  mem_en_c;

  logic                  fifo_pop;
  logic                  fifo_valid;
  logic [FW-1:0]         fifo_dout;
  logic [1:0]            fifo_occ;

  assign fifo_pop = fifo_valid && i_TREADY;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    issued_d    = issued_q;
    inflight_d  = 1'b0;
    infl_last_d = 1'b0;
    mem_en_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_START) begin
          if (i_COUNT != '0) begin
            state_d  = RUN;
            base_d   = i_BASE;
            count_d  = i_COUNT;
            issued_d = '0;
          end else begin
            state_d = FIN;
          end
        end
      end
      RUN: begin
        // Issue only if the word is guaranteed a FIFO slot when it returns.
        if ((issued_q < count_q) &&
            (({1'b0, fifo_occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, fifo_pop}))) begin
          mem_en_c    = 1'b1;
          issued_d    = issued_q + CW'(1);
          inflight_d  = 1'b1;
          infl_last_d = (issued_q == (count_q - CW'(1)));
        end
        if (fifo_pop && fifo_dout[FW-1]) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
    end
  end

  outmem_drain_fifo #(
    .WIDTH (FW)
  ) u_fifo (
    .clk_i   (i_CLK),
    .rst_ni  (i_RSTn),
    .push_i  (inflight_q),
    .din_i   ({infl_last_q, i_MEM_RDATA}),
    .pop_i   (fifo_pop),
    .valid_o (fifo_valid),
    .dout_o  (fifo_dout),
    .occ_o   (fifo_occ)
  );

  assign o_BUSY      = (state_q != IDLE);
  assign o_DONE      = (state_q == FIN);
  assign o_MEM_EN    = mem_en_c;
  assign o_MEM_ADDR  = mem_en_c ? ADDR_WIDTH'(base_q + issued_q[ADDR_WIDTH-1:0]) : '0;
  assign o_MEM_WDATA = '0;
`ifdef OUTMEM_DRAIN_CLEAR_EN
  assign o_MEM_WE    = mem_en_c;
`else
  assign o_MEM_WE    = 1'b0;
`endif
  assign o_TVALID    = fifo_valid;
  assign o_TDATA     = fifo_valid ? fifo_dout[DATA_WIDTH-1:0] : '0;
  assign o_TLAST     = fifo_valid && fifo_dout[FW-1];

endmodule

// File: tb/tb_outmem_drain.sv
// Randomized self-checking bench for outmem_drain against a queue-based reference of the drain sequence.
module tb_outmem_drain;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;
`ifdef OUTMEM_DRAIN_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          i_RSTn = 1'b0;
  logic          i_START = 1'b0;
  logic [AW-1:0] i_BASE = '0;
  logic [AW:0]   i_COUNT = '0;
  logic          o_BUSY, o_DONE, o_MEM_EN, o_MEM_WE;
  logic [AW-1:0] o_MEM_ADDR;
  logic [DW-1:0] o_MEM_WDATA;
  logic [DW-1:0] i_MEM_RDATA = '0;
  logic          o_TVALID;
  logic          i_TREADY = 1'b0;
  logic [DW-1:0] o_TDATA;
  logic          o_TLAST;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  outmem_drain dut (
    .i_CLK       (clk),
    .i_RSTn      (i_RSTn),
    .i_START     (i_START),
    .i_BASE      (i_BASE),
    .i_COUNT     (i_COUNT),
    .o_BUSY      (o_BUSY),
    .o_DONE      (o_DONE),
    .o_MEM_EN    (o_MEM_EN),
    .o_MEM_WE    (o_MEM_WE),
    .o_MEM_ADDR  (o_MEM_ADDR),
    .o_MEM_WDATA (o_MEM_WDATA),
    .i_MEM_RDATA (i_MEM_RDATA),
    .o_TVALID    (o_TVALID),
    .i_TREADY    (i_TREADY),
    .o_TDATA     (o_TDATA),
    .o_TLAST     (o_TLAST)
  );

  // Read-first port B with 1-cycle latency; load rewrites mem[i]=i.
  logic [DW-1:0] mem [DEPTH];
  logic          load = 1'b0;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= DW'(i);
    end else if (o_MEM_EN) begin
      i_MEM_RDATA <= mem[o_MEM_ADDR];
      if (o_MEM_WE) mem[o_MEM_ADDR] <= o_MEM_WDATA;
    end
  end

  logic [DW-1:0] ref_mem [DEPTH];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic preload();
    @(negedge clk);
    load = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = DW'(i);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  DW'(o_BUSY), '0);
    chk({tag, "_done"},  DW'(o_DONE), '0);
    chk({tag, "_en"},    DW'(o_MEM_EN), '0);
    chk({tag, "_we"},    DW'(o_MEM_WE), '0);
    chk({tag, "_addr"},  DW'(o_MEM_ADDR), '0);
    chk({tag, "_valid"}, DW'(o_TVALID), '0);
    chk({tag, "_data"},  o_TDATA, '0);
    chk({tag, "_last"},  DW'(o_TLAST), '0);
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  // One drain: builds the expected address/word sequence, then checks the DUT cycle by cycle.
  task automatic run_drain(input int base, input int cnt, input int mode, input int abort_after);
    int            exp_a [$];
    logic [DW:0]   exp_d [$];
    logic [DW:0]   e;
    int            a, cyc, issued, popped, first_v, first_hs, last_hs;
    bit            seen_done, aborted;
    logic          pv, pr, pl;
    logic [DW-1:0] pd;

    for (int k = 0; k < cnt; k++) begin
      a = (base + k) % int'(DEPTH);
      exp_a.push_back(a);
      e = {(k == cnt - 1), ref_mem[a]};
      exp_d.push_back(e);
      if (CLR) ref_mem[a] = '0;
    end

    cyc = 0; issued = 0; popped = 0; first_v = -1; first_hs = -1; last_hs = -1;
    seen_done = 1'b0; aborted = 1'b0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;

    for (int guard = 0; guard < 400; guard++) begin
      @(negedge clk);
      i_START  = (cyc == 0);
      i_BASE   = AW'(base);
      i_COUNT  = (AW + 1)'(cnt);
      i_TREADY = ready_for(mode, cyc);
      #1;
      if (cyc == 0) chk("idle_busy", DW'(o_BUSY), '0);
      else          chk("busy", DW'(o_BUSY), DW'(1));
      if (cyc == 1 && cnt > 0) chk("first_en", DW'(o_MEM_EN), DW'(1));
      if (o_MEM_EN) begin
        if (exp_a.size() == 0) chk("extra_en", DW'(1), '0);
        else                   chk("addr", DW'(o_MEM_ADDR), DW'(exp_a.pop_front()));
        chk("we", DW'(o_MEM_WE), DW'(CLR));
        chk("wdata", o_MEM_WDATA, '0);
      end
      if (o_TVALID) begin
        if (first_v < 0) begin
          first_v = cyc;
          chk("first_valid_cyc", DW'(cyc), DW'(3));
        end
        if (pv && !pr) begin
          chk("stall_data", o_TDATA, pd);
          chk("stall_last", DW'(o_TLAST), DW'(pl));
        end
        if (i_TREADY) begin
          if (exp_d.size() == 0) chk("extra_word", DW'(1), '0);
          else begin
            e = exp_d.pop_front();
            chk("tdata", o_TDATA, e[DW-1:0]);
            chk("tlast", DW'(o_TLAST), DW'(e[DW]));
          end
          popped++;
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
        end
      end else if (pv && !pr) begin
        chk("stall_valid", DW'(o_TVALID), DW'(1));
      end
      if (o_MEM_EN) begin
        issued++;
        chk("buffered_le2", DW'((issued - popped) <= 2), DW'(1));
      end
      pv = o_TVALID; pr = i_TREADY; pd = o_TDATA; pl = o_TLAST;
      if (o_DONE) begin
        chk("done_cyc", DW'(cyc), DW'((cnt == 0) ? 1 : last_hs + 1));
        seen_done = 1'b1;
        break;
      end
      if (abort_after > 0 && popped == abort_after) begin
        aborted = 1'b1;
        break;
      end
      cyc++;
    end

    if (aborted) begin
      @(negedge clk);
      i_START = 1'b0;
      i_RSTn  = 1'b0;
      @(negedge clk);
      i_RSTn  = 1'b1;
      #1;
      chk_zero("post_rst");
    end else begin
      if (!seen_done) chk("timeout", '0, DW'(1));
      chk("words_left", DW'(exp_d.size()), '0);
      chk("addr_left", DW'(exp_a.size()), '0);
      if (mode == 0 && cnt > 0) chk("back2back", DW'(last_hs - first_hs), DW'(cnt - 1));
      if (cnt == 0) chk("zero_no_valid", DW'(first_v < 0), DW'(1));
      @(negedge clk);
      i_START = 1'b0;
      #1;
      chk("busy_after", DW'(o_BUSY), '0);
      chk("done_pulse", DW'(o_DONE), '0);
    end
  endtask

  initial begin
    i_RSTn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    i_RSTn = 1'b1;

    preload();
    run_drain(3, 4, 0, 0);
    run_drain(30, 5, 0, 0);
    preload();
    run_drain(0, 32, 1, 0);
    run_drain(7, 0, 0, 0);
    preload();
    run_drain(5, 8, 0, 2);
    preload();
    run_drain(0, 2, 0, 0);
    preload();
    run_drain(0, 4, 0, 0);
    run_drain(0, 4, 0, 0);
    preload();
    for (int r = 0; r < 8; r++) begin
      run_drain(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), 2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
